// File: rtl/circuito_jogo_param_if.sv
// Player, sequence-memory and status signals of the progressive memory game.
interface circuito_jogo_param_if #(
    parameter int N_CHAVES     = 4,
    parameter int PROFUNDIDADE = 16
);
    localparam int AW = $clog2(PROFUNDIDADE);

    logic                iniciar;
    logic [N_CHAVES-1:0] chaves;
    logic                nivel;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [N_CHAVES-1:0] mem_dado;
    logic                acertou;
    logic                errou;
    logic                timeout;
    logic                pronto;
    logic [N_CHAVES-1:0] leds;
    logic [3:0]          db_estado;
    logic [AW-1:0]       db_rodada;
    logic [AW-1:0]       db_jogada;

    modport master (
        output iniciar, chaves, nivel, mem_we, mem_addr, mem_dado,
        input  acertou, errou, timeout, pronto, leds, db_estado, db_rodada, db_jogada
    );

    modport slave (
        input  iniciar, chaves, nivel, mem_we, mem_addr, mem_dado,
        output acertou, errou, timeout, pronto, leds, db_estado, db_rodada, db_jogada
    );
endinterface

// File: rtl/circuito_jogo_param.sv
// Progressive memory game: in round r the player repeats sequence entries 0..r,
// with a per-move time limit and a sequence memory writable only between games.
module circuito_jogo_param #(
    parameter int N_CHAVES     = 4,
    parameter int PROFUNDIDADE = 16,
    parameter int TIMEOUT      = 5000
) (
    input  logic                 clock,
    input  logic                 reset,
    circuito_jogo_param_if.slave bus
);
    localparam int AW = $clog2(PROFUNDIDADE);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] ULTIMA_CHEIA = AW'(PROFUNDIDADE - 1);
    localparam logic [AW-1:0] ULTIMA_CURTA = AW'(PROFUNDIDADE / 2 - 1);
    localparam logic [CW-1:0] TEMPO_MAX    = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARA     = 4'h4,
        PROX_JOGADA = 4'h5,
        PROX_RODADA = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [AW-1:0]       rodada_q, rodada_d;
    logic [AW-1:0]       jogada_q, jogada_d;
    logic [CW-1:0]       tempo_q, tempo_d;
    logic [N_CHAVES-1:0] leds_q, leds_d;
    logic                nivel_q, nivel_d;
    logic [N_CHAVES-1:0] chaves_ant_q;
    logic [N_CHAVES-1:0] mem [PROFUNDIDADE];

    logic jogada_feita;
    logic ultima_rodada;
    logic acerto;
    logic pode_gravar;

    // Edge detect on the button bus: a held button produces a single move.
    assign jogada_feita  = (bus.chaves != '0) && (chaves_ant_q == '0);
    assign ultima_rodada = (rodada_q == (nivel_q ? ULTIMA_CHEIA : ULTIMA_CURTA));
    assign acerto        = (leds_q != '0)
                        && ((leds_q & (leds_q - N_CHAVES'(1))) == '0)
                        && (leds_q == mem[jogada_q]);
    assign pode_gravar   = (estado_q == INICIAL) || (estado_q == FIM_ACERTO)
                        || (estado_q == FIM_ERRO) || (estado_q == FIM_TIMEOUT);

    always_comb begin
        estado_d = estado_q;
        rodada_d = rodada_q;
        jogada_d = jogada_q;
        leds_d   = leds_q;
        nivel_d  = nivel_q;
        tempo_d  = '0;
        case (estado_q)
            INICIAL: if (bus.iniciar) estado_d = PREPARA;
            PREPARA: begin
                rodada_d = '0;
                jogada_d = '0;
                leds_d   = '0;
                nivel_d  = bus.nivel;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (jogada_feita) begin
                    leds_d   = bus.chaves;
                    estado_d = REGISTRA;
                end else if (tempo_q == TEMPO_MAX) begin
                    estado_d = FIM_TIMEOUT;
                end else begin
                    tempo_d = tempo_q + CW'(1);
                end
            end
            REGISTRA: estado_d = COMPARA;
            COMPARA: begin
                if (!acerto)                 estado_d = FIM_ERRO;
                else if (jogada_q < rodada_q) estado_d = PROX_JOGADA;
                else if (!ultima_rodada)     estado_d = PROX_RODADA;
                else                         estado_d = FIM_ACERTO;
            end
            PROX_JOGADA: begin
                jogada_d = jogada_q + AW'(1);
                estado_d = ESPERA;
            end
            PROX_RODADA: begin
                rodada_d = rodada_q + AW'(1);
                jogada_d = '0;
                estado_d = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (bus.iniciar) estado_d = PREPARA;
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= INICIAL;
            rodada_q     <= '0;
            jogada_q     <= '0;
            tempo_q      <= '0;
            leds_q       <= '0;
            nivel_q      <= 1'b0;
            chaves_ant_q <= '0;
        end else begin
            estado_q     <= estado_d;
            rodada_q     <= rodada_d;
            jogada_q     <= jogada_d;
            tempo_q      <= tempo_d;
            leds_q       <= leds_d;
            nivel_q      <= nivel_d;
            chaves_ant_q <= bus.chaves;
        end
    end

    // Sequence storage has no reset; writes are accepted only between games.
    always_ff @(posedge clock) begin
        if (!reset && bus.mem_we && pode_gravar) mem[bus.mem_addr] <= bus.mem_dado;
    end

    assign bus.db_estado = estado_q;
    assign bus.db_rodada = rodada_q;
    assign bus.db_jogada = jogada_q;
    assign bus.leds      = leds_q;
    assign bus.acertou   = (estado_q == FIM_ACERTO);
    assign bus.errou     = (estado_q == FIM_ERRO);
    assign bus.timeout   = (estado_q == FIM_TIMEOUT);
    assign bus.pronto    = (estado_q == FIM_ACERTO) || (estado_q == FIM_ERRO)
                        || (estado_q == FIM_TIMEOUT);
endmodule

// File: tb/tb_circuito_jogo_param.sv
// Randomized games against a sequence-level model of the memory game.
module tb_circuito_jogo_param;
    localparam int N  = 4;
    localparam int P  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iniciar = 1'b0;
    logic [N-1:0]  chaves = '0;
    logic          nivel = 1'b0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [N-1:0]  mem_dado = '0;

    int n_testes = 0;
    int n_falhas = 0;
    int mem_m [P];
    int atraso = 0;

    always #5 clk = ~clk;

    circuito_jogo_param_if #(.N_CHAVES(N), .PROFUNDIDADE(P)) if_a ();
    circuito_jogo_param_if #(.N_CHAVES(N), .PROFUNDIDADE(P)) if_b ();

    assign if_a.iniciar  = iniciar;
    assign if_a.chaves   = chaves;
    assign if_a.nivel    = nivel;
    assign if_a.mem_we   = mem_we;
    assign if_a.mem_addr = mem_addr;
    assign if_a.mem_dado = mem_dado;
    assign if_b.iniciar  = iniciar;
    assign if_b.chaves   = chaves;
    assign if_b.nivel    = nivel;
    assign if_b.mem_we   = mem_we;
    assign if_b.mem_addr = mem_addr;
    assign if_b.mem_dado = mem_dado;

    circuito_jogo_param #(.N_CHAVES(N), .PROFUNDIDADE(P), .TIMEOUT(10)) dut_a (
        .clock(clk), .reset(rst), .bus(if_a.slave)
    );
    circuito_jogo_param #(.N_CHAVES(N), .PROFUNDIDADE(P), .TIMEOUT(40)) dut_b (
        .clock(clk), .reset(rst), .bus(if_b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_testes++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_a(input logic [3:0] alvo, input int lim, output int c);
        c = 0;
        while (if_a.db_estado !== alvo && c < lim) begin
            tick();
            c++;
        end
    endtask

    task automatic chk_fim(input logic [3:0] cod, input bit a, input bit e, input bit t, input int l);
        chk("fim_estado", 32'(if_a.db_estado), 32'(cod));
        chk("fim_acertou", 32'(if_a.acertou), 32'(a));
        chk("fim_errou", 32'(if_a.errou), 32'(e));
        chk("fim_timeout", 32'(if_a.timeout), 32'(t));
        chk("fim_pronto", 32'(if_a.pronto), 32'd1);
        chk("fim_leds", 32'(if_a.leds), 32'(l));
    endtask

    task automatic do_reset(input bit com_lixo);
        rst = 1'b1;
        if (com_lixo) begin
            iniciar  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = '0;
            mem_dado = N'(mem_m[0]) ^ 4'hF;
        end
        tick();
        rst = 1'b0;
        iniciar = 1'b0;
        mem_we = 1'b0;
        chk("rst_estado", 32'(if_a.db_estado), 32'd0);
        chk("rst_estado_b", 32'(if_b.db_estado), 32'd0);
        chk("rst_flags", 32'({if_a.acertou, if_a.errou, if_a.timeout, if_a.pronto}), 32'd0);
        chk("rst_leds", 32'(if_a.leds), 32'd0);
        chk("rst_rodada", 32'(if_a.db_rodada), 32'd0);
        chk("rst_jogada", 32'(if_a.db_jogada), 32'd0);
    endtask

    task automatic load_mem(input bit aleatorio);
        for (int a = 0; a < P; a++) begin
            mem_m[a] = aleatorio ? (1 << $urandom_range(0, N - 1)) : (1 << a);
            mem_we   = 1'b1;
            mem_addr = AW'(a);
            mem_dado = N'(mem_m[a]);
            tick();
        end
        mem_we = 1'b0;
    endtask

    task automatic start_game(input bit nv, input bit escreve_espera);
        int c;
        nivel = nv;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        wait_a(4'h2, 5, c);
        chk("ini_estado", 32'(if_a.db_estado), 32'h2);
        chk("ini_rodada", 32'(if_a.db_rodada), 32'd0);
        chk("ini_jogada", 32'(if_a.db_jogada), 32'd0);
        chk("ini_leds", 32'(if_a.leds), 32'd0);
        chk("ini_pronto", 32'(if_a.pronto), 32'd0);
        if (escreve_espera) begin
            mem_we   = 1'b1;
            mem_addr = AW'(1);
            mem_dado = 4'h8;
            tick();
            mem_we = 1'b0;
            atraso = 1;
        end
    endtask

    task automatic press(input int v);
        int idle;
        idle = ($urandom_range(0, 3) == 0) ? 9 - atraso : int'($urandom_range(0, 9 - atraso));
        atraso = 0;
        repeat (idle) tick();
        chaves = N'(v);
        repeat ($urandom_range(1, 3)) tick();
        chaves = '0;
    endtask

    // modo: 0 all correct, 1 wrong value at move pos, 2 silence at move pos, 3 stop before move pos
    task automatic play_game(input bit nv, input int modo, input int pos_in, input int errado,
                             input bit escreve_espera);
        int sv[$];
        int sr[$];
        int sj[$];
        int pos, v, ultimo, c;
        for (int r = 0; r < (nv ? P : P / 2); r++)
            for (int j = 0; j <= r; j++) begin
                sv.push_back(mem_m[j]);
                sr.push_back(r);
                sj.push_back(j);
            end
        pos = pos_in % sv.size();
        start_game(nv, escreve_espera);
        ultimo = 0;
        for (int k = 0; k < sv.size(); k++) begin
            if (modo == 3 && k == pos) return;
            if (modo == 2 && k == pos) begin
                wait_a(4'hD, 30, c);
                chk("ciclos_timeout", 32'(c), 32'd10);
                chk_fim(4'hD, 1'b0, 1'b0, 1'b1, ultimo);
                return;
            end
            v = sv[k];
            if (modo == 1 && k == pos) begin
                v = errado;
                while (v == 0 || v == sv[k]) v = int'($urandom_range(1, (1 << N) - 1));
            end
            press(v);
            ultimo = v;
            if (v != sv[k]) begin
                wait_a(4'hE, 8, c);
                chk_fim(4'hE, 1'b0, 1'b1, 1'b0, v);
                return;
            end
            if (k == sv.size() - 1) begin
                wait_a(4'hA, 8, c);
                chk_fim(4'hA, 1'b1, 1'b0, 1'b0, v);
            end else begin
                wait_a(4'h2, 8, c);
                chk("prox_estado", 32'(if_a.db_estado), 32'h2);
                chk("prox_rodada", 32'(if_a.db_rodada), 32'(sr[k+1]));
                chk("prox_jogada", 32'(if_a.db_jogada), 32'(sj[k+1]));
                chk("prox_pronto", 32'(if_a.pronto), 32'd0);
            end
        end
    endtask

    initial begin
        int c;
        tick();
        tick();
        do_reset(1'b0);

        // Fixed sequence 1,2,4,8: full game, short game, wrong second move of round 1
        load_mem(1'b0);
        play_game(1'b1, 0, 0, 0, 1'b0);
        play_game(1'b0, 0, 0, 0, 1'b0);
        play_game(1'b1, 1, 2, 4, 1'b0);
        chk("erro_leds4", 32'(if_a.leds), 32'd4);
        play_game(1'b1, 2, 0, 0, 1'b0);

        for (int g = 0; g < 14; g++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_reset(1'b0);
                load_mem(1'b1);
            end
            play_game(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 9)), 0, 1'b0);
        end

        // Held button in round 1 counts once; the 10-cycle instance times out meanwhile
        do_reset(1'b0);
        load_mem(1'b0);
        start_game(1'b1, 1'b0);
        press(mem_m[0]);
        wait_a(4'h2, 8, c);
        chaves = N'(mem_m[0]);
        repeat (20) tick();
        chk("hold_estado_b", 32'(if_b.db_estado), 32'h2);
        chk("hold_jogada_b", 32'(if_b.db_jogada), 32'd1);
        chk("hold_rodada_b", 32'(if_b.db_rodada), 32'd1);
        chk("hold_estado_a", 32'(if_a.db_estado), 32'hD);
        chaves = '0;
        tick();
        chaves = N'(mem_m[1]);
        tick();
        chaves = '0;
        repeat (3) tick();
        chk("hold2_estado_b", 32'(if_b.db_estado), 32'h2);
        chk("hold2_rodada_b", 32'(if_b.db_rodada), 32'd2);
        chk("hold2_jogada_b", 32'(if_b.db_jogada), 32'd0);

        // Reset mid round 2 (with start and write requested), then a write during ESPERA
        do_reset(1'b0);
        load_mem(1'b0);
        play_game(1'b1, 3, 4, 0, 1'b0);
        chk("meio_rodada", 32'(if_a.db_rodada), 32'd2);
        do_reset(1'b1);
        tick();
        chk("pos_rst_estado", 32'(if_a.db_estado), 32'd0);
        play_game(1'b1, 0, 0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1);
    end
endmodule

// File: doc/circuito_jogo_param.md
CIRCUITO_JOGO_PARAM -- requirements
Module: circuito_jogo_param

Interface
REQ-001 Parameter N_CHAVES, default 4: number of buttons/LEDs; legal range 2..16.
REQ-002 Parameter PROFUNDIDADE, default 16: sequence memory depth; power of two; legal range 4..64.
REQ-003 Parameter TIMEOUT, default 5000: clock cycles allowed per move; legal range >= 2.
REQ-004 Local width AW = clog2(PROFUNDIDADE); CW = clog2(TIMEOUT).
REQ-005 clock  in  1  single clock domain; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 iniciar  in  1  start/restart request, level-sampled.
REQ-008 chaves  in  N_CHAVES  player buttons, one-hot per move.
REQ-009 nivel  in  1  0 = short game of PROFUNDIDADE/2 rounds; 1 = full game of PROFUNDIDADE rounds.
REQ-010 mem_we, mem_addr[AW-1:0], mem_dado[N_CHAVES-1:0]  in  sequence-memory write port.
REQ-011 acertou, errou, timeout, pronto  out  1 each  game result flags.
REQ-012 leds  out  N_CHAVES  last registered move.
REQ-013 db_estado  out  4  state code; db_rodada, db_jogada  out  AW each  current round index and move index.

Function
REQ-014 The block SHALL be a progressive memory game: in round r (0-based), the player SHALL repeat memory entries 0..r in order.
REQ-015 States and codes: INICIAL 0, PREPARA 1, ESPERA 2, REGISTRA 3, COMPARA 4, PROX_JOGADA 5, PROX_RODADA 6, FIM_ACERTO A, FIM_ERRO E, FIM_TIMEOUT D; db_estado SHALL show the code; unused codes SHALL return to INICIAL on the next cycle.
REQ-016 INICIAL->PREPARA when iniciar=1; PREPARA SHALL zero round, move and timer counters and leds, and latch nivel; PREPARA->ESPERA unconditionally.
REQ-017 A move SHALL be detected when chaves != 0 in the current cycle and chaves == 0 in the previous cycle (registered copy); a held button SHALL count once.
REQ-018 In ESPERA, a detected move SHALL cause ESPERA->REGISTRA, storing chaves into the move register (leds) in that transition; REGISTRA->COMPARA next cycle.
REQ-019 COMPARA SHALL compare the move register against mem[db_jogada]; mismatch, including non-one-hot input, ->FIM_ERRO.
REQ-020 On match with db_jogada < db_rodada: ->PROX_JOGADA (increment move index) ->ESPERA.
REQ-021 On match with db_jogada == db_rodada and db_rodada < last round (nivel=1: PROFUNDIDADE-1; nivel=0: PROFUNDIDADE/2-1): ->PROX_RODADA (increment round, zero move index) ->ESPERA.
REQ-022 On match with db_jogada == db_rodada == last round: ->FIM_ACERTO.
REQ-023 The timer SHALL count only in ESPERA and clear on every exit from ESPERA; when it reaches TIMEOUT-1 with no move in that cycle: ->FIM_TIMEOUT. A move in the same cycle SHALL take priority over timeout.
REQ-024 Exactly one of acertou/errou/timeout SHALL be 1 in FIM_ACERTO, FIM_ERRO or FIM_TIMEOUT respectively; pronto SHALL be 1 in all three; all flags SHALL be 0 elsewhere.
REQ-025 Final states SHALL hold until iniciar=1, then ->PREPARA (new game, same memory).
REQ-026 Memory writes SHALL take effect only in INICIAL or final states; writes in other states SHALL be ignored.
REQ-027 Memory SHALL be synchronous-write and asynchronous-read; contents SHALL be undefined until written and unaffected by reset.

Reset
REQ-028 reset=1 SHALL force INICIAL on the next edge from any state, including mid-game, with all counters, timer and leds set to 0 and all flags set to 0.
REQ-029 reset SHALL take priority over iniciar and over mem_we.

Verification
REQ-030 With N_CHAVES=4 and PROFUNDIDADE=4, load mem = 1,2,4,8; set nivel=1; play the full progressive sequence (10 moves) -> acertou=1, pronto=1, db_estado=A.
REQ-031 With the same memory, nivel=0, play 1 | 1,2 -> FIM_ACERTO after round 1 (3 moves).
REQ-032 Round 1: enter 1, then 4 instead of 2 -> errou=1, db_estado=E, leds=4.
REQ-033 With TIMEOUT=10, do not press any button after start -> FIM_TIMEOUT exactly 10 cycles after entering ESPERA, timeout=1; a press arriving on the 10th cycle -> REGISTRA instead.
REQ-034 Hold chaves=1 for 20 cycles in round 1 -> only one move counted; db_jogada=1, state ESPERA.
REQ-035 Assert reset mid-round 2, then write to memory while in ESPERA -> reset: state 0, all outputs 0; the ESPERA write leaves memory unchanged (replay confirms the original sequence).
